// File: rtl/atmega_io_arbiter.sv
// Two-master arbiter for the 8-bit I/O register bus: the CPU gets zero-wait priority and a
// secondary master (DMA/debug) is slotted into idle cycles or forced in after a bounded wait.
module atmega_io_arbiter #(
  parameter int BUS_ADDR_DATA_LEN = 8,
  parameter int DATA_WIDTH        = 8,
  parameter int MAX_WAIT          = 15,
  parameter int WAIT_W            = 4
) (
  input  logic                         rst,
  input  logic                         clk,
  input  logic [BUS_ADDR_DATA_LEN-1:0] cpu_addr,
  input  logic                         cpu_wr,
  input  logic                         cpu_rd,
  input  logic [DATA_WIDTH-1:0]        cpu_wdata,
  output logic [DATA_WIDTH-1:0]        cpu_rdata,
  output logic                         cpu_stall,
  input  logic                         dma_req,
  input  logic                         dma_we,
  input  logic [BUS_ADDR_DATA_LEN-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0]        dma_wdata,
  output logic [DATA_WIDTH-1:0]        dma_rdata,
  output logic                         dma_ack,
  output logic [BUS_ADDR_DATA_LEN-1:0] bus_addr,
  output logic                         bus_wr,
  output logic                         bus_rd,
  output logic [DATA_WIDTH-1:0]        bus_wdata,
  input  logic [DATA_WIDTH-1:0]        bus_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                         state_q, state_d;
  logic [WAIT_W-1:0]              wait_cnt_q, wait_cnt_d;
  logic                           lat_we_q, lat_we_d;
  logic [BUS_ADDR_DATA_LEN-1:0]   lat_addr_q, lat_addr_d;
  logic [DATA_WIDTH-1:0]          lat_wdata_q, lat_wdata_d;
  logic [DATA_WIDTH-1:0]          dma_rdata_q, dma_rdata_d;
  logic                           cpu_busy;
  logic                           wait_expired;

  assign cpu_busy     = cpu_wr | cpu_rd;
  assign wait_expired = (wait_cnt_q == WAIT_W'(MAX_WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    dma_rdata_d = dma_rdata_q;
    case (state_q)
      IDLE: begin
        if (dma_req) begin
          lat_we_d    = dma_we;
          lat_addr_d  = dma_addr;
          lat_wdata_d = dma_wdata;
          wait_cnt_d  = '0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        // A CPU-idle cycle is the free slot; otherwise count until the access is forced.
        if (!cpu_busy || wait_expired) begin
          state_d = ACCESS;
        end else if (wait_cnt_q != {WAIT_W{1'b1}}) begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ACCESS: begin
        if (!lat_we_q) begin
          dma_rdata_d = bus_rdata;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    cpu_stall = (state_q == ACCESS);
    dma_ack   = (state_q == DONE);
    dma_rdata = dma_rdata_q;
    if (cpu_stall) begin
      bus_addr  = lat_addr_q;
      bus_wr    = lat_we_q;
      bus_rd    = ~lat_we_q;
      bus_wdata = lat_wdata_q;
    end else begin
      bus_addr  = cpu_addr;
      bus_wr    = cpu_wr;
      bus_rd    = cpu_rd;
      bus_wdata = cpu_wdata;
    end
    // The read data during a DMA slot belongs to the DMA, never to the stalled CPU.
    cpu_rdata = (cpu_rd && !cpu_stall) ? bus_rdata : '0;
  end

endmodule

// File: tb/tb_atmega_io_arbiter.sv
// Bench for atmega_io_arbiter: a reset-relative vector table, directed timing sequences and
// a randomized run checked against a timestamp-based model of the DMA transaction lifecycle.
module tb_atmega_io_arbiter;

  localparam int MAX_WAIT = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
  logic       cpu_wr = 1'b0, cpu_rd = 1'b0, cpu_stall;
  logic       dma_req = 1'b0, dma_we = 1'b0, dma_ack;
  logic [7:0] dma_addr = '0, dma_wdata = '0, dma_rdata;
  logic [7:0] bus_addr, bus_wdata, bus_rdata = '0;
  logic       bus_wr, bus_rd;

  always #5 clk = ~clk;

  atmega_io_arbiter #(
    .BUS_ADDR_DATA_LEN(8), .DATA_WIDTH(8), .MAX_WAIT(MAX_WAIT), .WAIT_W(4)
  ) dut (
    .rst(rst), .clk(clk),
    .cpu_addr(cpu_addr), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .bus_addr(bus_addr), .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic       cwr, crd;
    logic [7:0] caddr, cwd;
    logic       req, we;
    logic [7:0] daddr, dwd, brd;
    logic       e_stall, e_ack, e_bwr, e_brd;
    logic [7:0] e_baddr, e_bwd, e_crd, e_drd;
  } vec_t;

  vec_t tbl[7];

  int n_cmp = 0;
  int n_bad = 0;
  int n = 0;

  // Reference model: one outstanding transaction described by when it was issued and
  // the cycle its bus slot was granted (-1 while still undecided).
  bit         m_valid;
  logic       m_we;
  logic [7:0] m_addr, m_wdata, m_rdata;
  int         m_issue, m_access;

  int   ack_cnt, last_ack, stall_cnt, last_stall_cyc;
  logic last_stall_obs;

  function automatic vec_t mk(input logic cwr, crd, input logic [7:0] caddr, cwd,
                              input logic req, we, input logic [7:0] daddr, dwd, brd,
                              input logic e_stall, e_ack, e_bwr, e_brd,
                              input logic [7:0] e_baddr, e_bwd, e_crd, e_drd);
    vec_t v;
    v.cwr = cwr; v.crd = crd; v.caddr = caddr; v.cwd = cwd;
    v.req = req; v.we = we; v.daddr = daddr; v.dwd = dwd; v.brd = brd;
    v.e_stall = e_stall; v.e_ack = e_ack; v.e_bwr = e_bwr; v.e_brd = e_brd;
    v.e_baddr = e_baddr; v.e_bwd = e_bwd; v.e_crd = e_crd; v.e_drd = e_drd;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, n, act, exp);
    end
  endtask

  task automatic set_in(input logic cwr, crd, input logic [7:0] caddr, cwd,
                        input logic req, we, input logic [7:0] daddr, dwd, brd);
    cpu_wr = cwr; cpu_rd = crd; cpu_addr = caddr; cpu_wdata = cwd;
    dma_req = req; dma_we = we; dma_addr = daddr; dma_wdata = dwd; bus_rdata = brd;
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
    m_issue = 0; m_access = -1;
  endtask

  // Inputs for cycle n are already applied; compare, advance the model, cross the edge.
  task automatic step();
    logic       e_stall, e_ack;
    logic [17:0] e_bus;
    logic [7:0] e_crd;
    #1;
    e_stall = m_valid && (m_access == n);
    e_ack   = m_valid && (m_access >= 0) && (n == m_access + 1);
    e_bus   = e_stall ? {m_we, ~m_we, m_addr, m_wdata} : {cpu_wr, cpu_rd, cpu_addr, cpu_wdata};
    e_crd   = (cpu_rd && !e_stall) ? bus_rdata : 8'h00;
    check("stall", 32'(cpu_stall), 32'(e_stall));
    check("ack", 32'(dma_ack), 32'(e_ack));
    check("bus", 32'({bus_wr, bus_rd, bus_addr, bus_wdata}), 32'(e_bus));
    check("cpu_rdata", 32'(cpu_rdata), 32'(e_crd));
    check("dma_rdata", 32'(dma_rdata), 32'(m_rdata));
    last_stall_obs = cpu_stall;
    if (dma_ack) begin ack_cnt++; last_ack = n; end
    if (cpu_stall) begin stall_cnt++; last_stall_cyc = n; end
    if (e_stall && !m_we) m_rdata = bus_rdata;
    if (e_ack) begin
      m_valid = 1'b0;
    end else if (m_valid && m_access < 0 && n > m_issue) begin
      if (!(cpu_wr || cpu_rd) || (n - m_issue - 1) == MAX_WAIT) m_access = n + 1;
    end else if (!m_valid && dma_req) begin
      m_valid = 1'b1; m_we = dma_we; m_addr = dma_addr; m_wdata = dma_wdata;
      m_issue = n; m_access = -1;
    end
    @(posedge clk);
    #1;
    n++;
  endtask

  // Asserted mid-cycle so the asynchronous clear is visible before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_ack", 32'(dma_ack), 32'd0);
    check("rst_dma_rdata", 32'(dma_rdata), 32'd0);
    check("rst_bus", 32'({bus_wr, bus_rd, bus_addr, bus_wdata}),
          32'({cpu_wr, cpu_rd, cpu_addr, cpu_wdata}));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    ack_cnt = 0; last_ack = -1; stall_cnt = 0; last_stall_cyc = -1; last_stall_obs = 1'b0;
  endtask

  initial begin
    logic [7:0] ca, cd, saved_addr;
    model_reset();
    @(posedge clk);
    #1;

    // Table: CPU write/read pass-through, then a DMA read into an idle CPU.
    tbl[0] = mk(1,0,8'h23,8'h5A, 0,0,8'h00,8'h00,8'h00, 0,0,1,0,8'h23,8'h5A,8'h00,8'h00);
    tbl[1] = mk(0,1,8'h10,8'h00, 0,0,8'h00,8'h00,8'h77, 0,0,0,1,8'h10,8'h00,8'h77,8'h00);
    tbl[2] = mk(0,0,8'h00,8'h00, 1,0,8'h24,8'h00,8'h00, 0,0,0,0,8'h00,8'h00,8'h00,8'h00);
    tbl[3] = mk(0,0,8'h00,8'h00, 1,1,8'h99,8'hEE,8'h00, 0,0,0,0,8'h00,8'h00,8'h00,8'h00);
    tbl[4] = mk(0,0,8'h00,8'h00, 1,1,8'h99,8'hEE,8'hC3, 1,0,0,1,8'h24,8'h00,8'h00,8'h00);
    tbl[5] = mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00,8'h00, 0,1,0,0,8'h00,8'h00,8'h00,8'hC3);
    tbl[6] = mk(0,1,8'h05,8'h00, 0,0,8'h00,8'h00,8'h11, 0,0,0,1,8'h05,8'h00,8'h11,8'hC3);
    do_reset();
    for (int i = 0; i < 7; i++) begin
      set_in(tbl[i].cwr, tbl[i].crd, tbl[i].caddr, tbl[i].cwd, tbl[i].req, tbl[i].we,
             tbl[i].daddr, tbl[i].dwd, tbl[i].brd);
      #1;
      check("tbl_stall", 32'(cpu_stall), 32'(tbl[i].e_stall));
      check("tbl_ack", 32'(dma_ack), 32'(tbl[i].e_ack));
      check("tbl_bus", 32'({bus_wr, bus_rd, bus_addr, bus_wdata}),
            32'({tbl[i].e_bwr, tbl[i].e_brd, tbl[i].e_baddr, tbl[i].e_bwd}));
      check("tbl_cpu_rdata", 32'(cpu_rdata), 32'(tbl[i].e_crd));
      check("tbl_dma_rdata", 32'(dma_rdata), 32'(tbl[i].e_drd));
      step();
    end

    // CPU busy every cycle: forced DMA write, single stall, stalled access re-issued.
    do_reset();
    ca = '0; cd = '0; saved_addr = '0;
    for (int k = 0; k < 22; k++) begin
      if (!last_stall_obs) begin ca = 8'(8'h40 + k); cd = 8'(k * 3); end
      set_in(1, 0, ca, cd, ack_cnt == 0, k == 0, k == 0 ? 8'h30 : 8'(k), k == 0 ? 8'hA5 : 8'h00,
             8'(k));
      if (k == 17) saved_addr = ca;
      if (k == 18) begin
        #1;
        check("reissue_addr", 32'({bus_wr, bus_addr}), 32'({1'b1, saved_addr}));
      end
      step();
    end
    check("forced_stall_cnt", 32'(stall_cnt), 32'd1);
    check("forced_stall_cycle", 32'(last_stall_cyc), 32'(MAX_WAIT + 2));
    check("forced_ack_cycle", 32'(last_ack), 32'(MAX_WAIT + 3));

    // CPU busy for three WAIT cycles, then idle.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      set_in(0, k >= 1 && k <= 3, 8'h50, 8'h00, ack_cnt == 0, 0, 8'h24, 8'h00, 8'h3C);
      step();
    end
    check("busy3_stall_cycle", 32'(last_stall_cyc), 32'd5);
    check("busy3_ack_cycle", 32'(last_ack), 32'd6);

    // Request held high: read, write, read, write at one access per four cycles.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      set_in(0, 0, 8'h00, 8'h00, 1, (k % 8) == 4, 8'(8'h60 + k), 8'(k), 8'($urandom));
      step();
    end
    check("b2b_ack_cnt", 32'(ack_cnt), 32'd4);
    check("b2b_last_ack", 32'(last_ack), 32'd15);

    // Reset while a second transaction sits in WAIT, then a fresh transaction.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      set_in(k >= 4, 0, 8'h70, 8'h01, k <= 4, 0, 8'h24, 8'h00, 8'h5C);
      step();
    end
    set_in(1, 0, 8'h71, 8'h02, 0, 0, 8'h00, 8'h00, 8'h5C);
    do_reset();
    for (int k = 0; k < 6; k++) begin
      set_in(0, 0, 8'h00, 8'h00, ack_cnt == 0, 0, 8'h2A, 8'h00, 8'h99);
      step();
    end
    check("post_rst_ack_cycle", 32'(last_ack), 32'd3);
    check("post_rst_ack_cnt", 32'(ack_cnt), 32'd1);

    // Randomized traffic with occasional asynchronous reset.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      set_in($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3, 8'($urandom), 8'($urandom),
             $urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 499) == 0) do_reset();
      else step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
